// File: rtl/bsg_dmc_ui_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_dmc_ui_arb_pkg
//  Brief    : Shared command codes and state encoding for the DMC UI arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package bsg_dmc_ui_arb_pkg;

    localparam logic [2:0] ARB_CMD_WR = 3'b000;
    localparam logic [2:0] ARB_CMD_RD = 3'b001;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/bsg_dmc_ui_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_dmc_ui_arbiter_if
//  Brief    : Controller-side app_* bundle (burst length 1) of bsg_dmc_wrap.
//  Revision : 1.0 - initial release
// ============================================================================
interface bsg_dmc_ui_arbiter_if #(
    parameter int UI_ADDR_WIDTH_P = 28,
    parameter int UI_DATA_WIDTH_P = 64
);
    logic [UI_ADDR_WIDTH_P-1:0]   app_addr;
    logic [2:0]                   app_cmd;
    logic                         app_en;
    logic [UI_DATA_WIDTH_P-1:0]   app_wdf_data;
    logic [UI_DATA_WIDTH_P/8-1:0] app_wdf_mask;
    logic                         app_wdf_wren;
    logic                         app_wdf_end;
    logic                         app_rdy;
    logic                         app_wdf_rdy;
    logic [UI_DATA_WIDTH_P-1:0]   app_rd_data;
    logic                         app_rd_data_valid;
    logic                         init_calib_complete;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
               app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
               init_calib_complete
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
               app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
               init_calib_complete
    );
endinterface
`default_nettype wire

// File: rtl/bsg_dmc_ui_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_dmc_ui_arb_tag_fifo
//  Brief    : In-order FIFO of requester ids for outstanding reads.
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_dmc_ui_arb_tag_fifo
    import bsg_dmc_ui_arb_pkg::*;
#(
    parameter int ID_W  = 1,
    parameter int DEPTH = 8,
    localparam int c_PTR_W = $clog2(DEPTH),
    localparam int c_CNT_W = c_PTR_W + 1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               push,
    input  wire logic [ID_W-1:0]    push_id,
    input  wire logic               pop,
    output logic      [ID_W-1:0]    pop_id,
    output logic                    full,
    output logic                    empty,
    output logic      [c_CNT_W-1:0] count
);
    logic [ID_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_id    = r_mem[r_rptr];
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/bsg_dmc_ui_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_dmc_ui_arbiter
//  Brief    : Round-robin sharing of one bsg_dmc_wrap app port between
//             requesters, with in-order steering of read data.
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_dmc_ui_arbiter
    import bsg_dmc_ui_arb_pkg::*;
#(
    parameter int NUM_REQ_P        = 2,
    parameter int UI_ADDR_WIDTH_P  = 28,
    parameter int UI_DATA_WIDTH_P  = 64,
    parameter int TAG_FIFO_DEPTH_P = 8,
    localparam int c_ID_W   = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1,
    localparam int c_MASK_W = UI_DATA_WIDTH_P / 8,
    localparam int c_CNT_W  = $clog2(TAG_FIFO_DEPTH_P) + 1
) (
    input  wire logic                                 ui_clk_i,
    input  wire logic                                 ui_reset_ni,
    input  wire logic [NUM_REQ_P-1:0]                 req_v_i,
    input  wire logic [NUM_REQ_P-1:0]                 req_we_i,
    input  wire logic [NUM_REQ_P*UI_ADDR_WIDTH_P-1:0] req_addr_i,
    input  wire logic [NUM_REQ_P*UI_DATA_WIDTH_P-1:0] req_wdata_i,
    input  wire logic [NUM_REQ_P*c_MASK_W-1:0]        req_wmask_i,
    output logic      [NUM_REQ_P-1:0]                 req_ready_o,
    output logic      [NUM_REQ_P-1:0]                 rsp_v_o,
    output logic      [UI_DATA_WIDTH_P-1:0]           rsp_data_o,
    bsg_dmc_ui_arbiter_if.master                      app,
    output logic                                      err_o
);
    localparam logic [0:0] c_ST_IDLE  = IDLE;
    localparam logic [0:0] c_ST_ISSUE = ISSUE;
    localparam logic [NUM_REQ_P-1:0] c_ONE = NUM_REQ_P'(1);

    // First eligible index strictly after last, wrapping; MSB flags a hit.
    function automatic logic [c_ID_W:0] rr_pick(input logic [NUM_REQ_P-1:0] elig,
                                                input logic [c_ID_W-1:0]    last);
        logic [c_ID_W:0] res;
        int              idx;
        res = '0;
        for (int i = NUM_REQ_P; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ_P;
            if (elig[idx]) res = {1'b1, c_ID_W'(idx)};
        end
        return res;
    endfunction

    logic [0:0]                 r_state;
    logic [c_ID_W-1:0]          r_last;
    logic [c_ID_W-1:0]          r_id;
    logic                       r_we;
    logic [2:0]                 r_cmd;
    logic [UI_ADDR_WIDTH_P-1:0] r_addr;
    logic [UI_DATA_WIDTH_P-1:0] r_wdata;
    logic [c_MASK_W-1:0]        r_wmask;
    logic                       r_cmd_done;
    logic                       r_data_done;
    logic [NUM_REQ_P-1:0]       r_rsp_v;
    logic [UI_DATA_WIDTH_P-1:0] r_rsp_data;
    logic                       r_err;

    logic [NUM_REQ_P-1:0] w_elig;
    logic [c_ID_W:0]      w_pick;
    logic [c_ID_W-1:0]    w_pick_id;
    logic                 w_grant;
    logic                 w_in_issue;
    logic                 w_cmd_hs;
    logic                 w_data_hs;
    logic                 w_done;
    logic                 w_tag_push;
    logic                 w_tag_pop;
    logic [c_ID_W-1:0]    w_tag_id;
    logic                 w_tag_full;
    logic                 w_tag_empty;
    logic [c_CNT_W-1:0]   w_tag_count;

    always_comb begin
        for (int k = 0; k < NUM_REQ_P; k++) begin
            w_elig[k] = req_v_i[k] && (req_we_i[k] || !w_tag_full);
        end
    end

    assign w_pick      = rr_pick(w_elig, r_last);
    assign w_pick_id   = w_pick[c_ID_W-1:0];
    assign w_in_issue  = (r_state == c_ST_ISSUE);
    // Reset gates the grant so every output is quiet while reset is held.
    assign w_grant     = ui_reset_ni && (r_state == c_ST_IDLE) &&
                         app.init_calib_complete && w_pick[c_ID_W];
    assign req_ready_o = w_grant ? (c_ONE << w_pick_id) : '0;

    assign app.app_en       = w_in_issue && !r_cmd_done;
    assign app.app_wdf_wren = w_in_issue && r_we && !r_data_done;
    assign app.app_wdf_end  = app.app_wdf_wren;
    assign app.app_cmd      = r_cmd;
    assign app.app_addr     = r_addr;
    assign app.app_wdf_data = r_wdata;
    assign app.app_wdf_mask = r_wmask;

    assign w_cmd_hs   = app.app_en && app.app_rdy;
    assign w_data_hs  = app.app_wdf_wren && app.app_wdf_rdy;
    assign w_done     = w_in_issue && (r_cmd_done || w_cmd_hs) &&
                        (!r_we || r_data_done || w_data_hs);
    assign w_tag_push = w_cmd_hs && !r_we;
    assign w_tag_pop  = app.app_rd_data_valid && !w_tag_empty;

    bsg_dmc_ui_arb_tag_fifo #(
        .ID_W  (c_ID_W),
        .DEPTH (TAG_FIFO_DEPTH_P)
    ) u_tag_fifo (
        .clk     (ui_clk_i),
        .rst_n   (ui_reset_ni),
        .push    (w_tag_push),
        .push_id (r_id),
        .pop     (w_tag_pop),
        .pop_id  (w_tag_id),
        .full    (w_tag_full),
        .empty   (w_tag_empty),
        .count   (w_tag_count)
    );

    always_ff @(posedge ui_clk_i or negedge ui_reset_ni) begin
        if (!ui_reset_ni) begin
            r_state     <= c_ST_IDLE;
            r_last      <= c_ID_W'(NUM_REQ_P - 1);
            r_id        <= '0;
            r_we        <= 1'b0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_cmd_done  <= 1'b0;
            r_data_done <= 1'b0;
        end else if (w_grant) begin
            r_state <= c_ST_ISSUE;
            r_last  <= w_pick_id;
            r_id    <= w_pick_id;
            r_we    <= req_we_i[w_pick_id];
            r_cmd   <= req_we_i[w_pick_id] ? ARB_CMD_WR : ARB_CMD_RD;
            r_addr  <= req_addr_i[int'(w_pick_id)*UI_ADDR_WIDTH_P +: UI_ADDR_WIDTH_P];
            r_wdata <= req_wdata_i[int'(w_pick_id)*UI_DATA_WIDTH_P +: UI_DATA_WIDTH_P];
            r_wmask <= req_wmask_i[int'(w_pick_id)*c_MASK_W +: c_MASK_W];
        end else if (w_done) begin
            r_state     <= c_ST_IDLE;
            r_cmd_done  <= 1'b0;
            r_data_done <= 1'b0;
        end else begin
            if (w_cmd_hs)  r_cmd_done  <= 1'b1;
            if (w_data_hs) r_data_done <= 1'b1;
        end
    end

    // Read return: one-cycle registered steering; a beat with no tag is an error.
    always_ff @(posedge ui_clk_i or negedge ui_reset_ni) begin
        if (!ui_reset_ni) begin
            r_rsp_v    <= '0;
            r_rsp_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rsp_v <= w_tag_pop ? (c_ONE << w_tag_id) : '0;
            if (w_tag_pop) r_rsp_data <= app.app_rd_data;
            if (app.app_rd_data_valid && (w_tag_count == '0)) r_err <= 1'b1;
        end
    end

    assign rsp_v_o    = r_rsp_v;
    assign rsp_data_o = r_rsp_data;
    assign err_o      = r_err;
endmodule
`default_nettype wire

// File: tb/tb_bsg_dmc_ui_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_dmc_ui_arbiter
//  Brief    : Directed vector bench for the DMC UI round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_dmc_ui_arbiter;
    localparam int c_N = 2;
    localparam int c_AW = 28;
    localparam int c_DW = 64;

    logic clk;
    logic rst_n;
    logic [c_N-1:0]      req_v;
    logic [c_N-1:0]      req_we;
    logic [c_N*c_AW-1:0] req_addr;
    logic [c_N*c_DW-1:0] req_wdata;
    logic [c_N*8-1:0]    req_wmask;
    logic [c_N-1:0]      req_ready;
    logic [c_N-1:0]      rsp_v;
    logic [c_DW-1:0]     rsp_data;
    logic                err;

    int n_chk;
    int n_err;

    bsg_dmc_ui_arbiter_if #(.UI_ADDR_WIDTH_P(c_AW), .UI_DATA_WIDTH_P(c_DW)) app_if ();

    bsg_dmc_ui_arbiter #(
        .NUM_REQ_P        (c_N),
        .UI_ADDR_WIDTH_P  (c_AW),
        .UI_DATA_WIDTH_P  (c_DW),
        .TAG_FIFO_DEPTH_P (8)
    ) dut (
        .ui_clk_i    (clk),
        .ui_reset_ni (rst_n),
        .req_v_i     (req_v),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wmask_i (req_wmask),
        .req_ready_o (req_ready),
        .rsp_v_o     (rsp_v),
        .rsp_data_o  (rsp_data),
        .app         (app_if.master),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  we;
        logic        rdy;
        logic        wrdy;
        logic        rdv;
        logic [63:0] rdata;
        logic        cal;
        logic [1:0]  e_ready;
        logic        e_en;
        logic        e_wren;
        logic        e_id;
        logic        e_we;
        logic [1:0]  e_rspv;
        logic [63:0] e_rdata;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, we, input logic rdy, wrdy, rdv,
                                input logic [63:0] rdata, input logic cal,
                                input logic [1:0] e_ready, input logic e_en, e_wren,
                                e_id, e_we, input logic [1:0] e_rspv,
                                input logic [63:0] e_rdata, input logic e_err);
        vec_t t;
        t.v = v; t.we = we; t.rdy = rdy; t.wrdy = wrdy; t.rdv = rdv; t.rdata = rdata;
        t.cal = cal; t.e_ready = e_ready; t.e_en = e_en; t.e_wren = e_wren;
        t.e_id = e_id; t.e_we = e_we; t.e_rspv = e_rspv; t.e_rdata = e_rdata;
        t.e_err = e_err;
        return t;
    endfunction

    function automatic logic [c_AW-1:0] exp_addr(input logic id);
        return id ? 28'h0A00011 : 28'h0A00010;
    endfunction
    function automatic logic [c_DW-1:0] exp_wdata(input logic id);
        return id ? 64'h1111_2222_3333_4444 : 64'h5555_6666_7777_8888;
    endfunction
    function automatic logic [7:0] exp_wmask(input logic id);
        return id ? 8'h0F : 8'hF0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then check once settled.
    task automatic step(input vec_t t, input string tag);
        @(posedge clk);
        #1;
        req_v = t.v;
        req_we = t.we;
        app_if.app_rdy = t.rdy;
        app_if.app_wdf_rdy = t.wrdy;
        app_if.app_rd_data_valid = t.rdv;
        app_if.app_rd_data = t.rdata;
        app_if.init_calib_complete = t.cal;
        #1;
        chk({tag, ".ready"}, 64'(req_ready), 64'(t.e_ready));
        chk({tag, ".app_en"}, 64'(app_if.app_en), 64'(t.e_en));
        chk({tag, ".wren"}, 64'(app_if.app_wdf_wren), 64'(t.e_wren));
        chk({tag, ".wdf_end"}, 64'(app_if.app_wdf_end), 64'(t.e_wren));
        chk({tag, ".rsp_v"}, 64'(rsp_v), 64'(t.e_rspv));
        chk({tag, ".err"}, 64'(err), 64'(t.e_err));
        if (t.e_rspv != 2'b00) chk({tag, ".rsp_data"}, rsp_data, t.e_rdata);
        if (t.e_en) begin
            chk({tag, ".cmd"}, 64'(app_if.app_cmd), t.e_we ? 64'd0 : 64'd1);
            chk({tag, ".addr"}, 64'(app_if.app_addr), 64'(exp_addr(t.e_id)));
        end
        if (t.e_wren) begin
            chk({tag, ".wdata"}, app_if.app_wdf_data, exp_wdata(t.e_id));
            chk({tag, ".wmask"}, 64'(app_if.app_wdf_mask), 64'(exp_wmask(t.e_id)));
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".ready"}, 64'(req_ready), 64'd0);
        chk({tag, ".app_en"}, 64'(app_if.app_en), 64'd0);
        chk({tag, ".wren"}, 64'(app_if.app_wdf_wren), 64'd0);
        chk({tag, ".rsp_v"}, 64'(rsp_v), 64'd0);
        chk({tag, ".err"}, 64'(err), 64'd0);
        chk({tag, ".cmd"}, 64'(app_if.app_cmd), 64'd0);
        chk({tag, ".addr"}, 64'(app_if.app_addr), 64'd0);
        chk({tag, ".wdata"}, app_if.app_wdf_data, 64'd0);
        chk({tag, ".rsp_data"}, rsp_data, 64'd0);
    endtask

    vec_t tbl [21];

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        req_v = 2'b11;
        req_we = 2'b00;
        req_addr = {28'h0A00011, 28'h0A00010};
        req_wdata = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        req_wmask = {8'h0F, 8'hF0};
        app_if.app_rdy = 1'b1;
        app_if.app_wdf_rdy = 1'b1;
        app_if.app_rd_data_valid = 1'b0;
        app_if.app_rd_data = '0;
        app_if.init_calib_complete = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_v = 2'b00;
        app_if.init_calib_complete = 1'b0;

        // v we rdy wrdy rdv rdata cal | ready en wren id we rspv rdata err
        tbl[0]  = mk(2'b11, 2'b00, 1, 1, 0, 64'h0,  0, 2'b00, 0, 0, 0, 0, 2'b00, 64'h0,  0);
        tbl[1]  = mk(2'b11, 2'b00, 1, 1, 0, 64'h0,  0, 2'b00, 0, 0, 0, 0, 2'b00, 64'h0,  0);
        tbl[2]  = mk(2'b11, 2'b00, 1, 1, 0, 64'h0,  1, 2'b01, 0, 0, 0, 0, 2'b00, 64'h0,  0);
        tbl[3]  = mk(2'b11, 2'b00, 1, 1, 0, 64'h0,  1, 2'b00, 1, 0, 0, 0, 2'b00, 64'h0,  0);
        tbl[4]  = mk(2'b11, 2'b00, 1, 1, 0, 64'h0,  1, 2'b10, 0, 0, 0, 0, 2'b00, 64'h0,  0);
        tbl[5]  = mk(2'b11, 2'b00, 1, 1, 0, 64'h0,  1, 2'b00, 1, 0, 1, 0, 2'b00, 64'h0,  0);
        tbl[6]  = mk(2'b11, 2'b00, 1, 1, 1, 64'hA0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 64'h0,  0);
        tbl[7]  = mk(2'b11, 2'b00, 1, 1, 1, 64'hA1, 1, 2'b00, 1, 0, 0, 0, 2'b01, 64'hA0, 0);
        tbl[8]  = mk(2'b10, 2'b00, 1, 1, 0, 64'h0,  1, 2'b10, 0, 0, 0, 0, 2'b10, 64'hA1, 0);
        tbl[9]  = mk(2'b00, 2'b00, 1, 1, 0, 64'h0,  1, 2'b00, 1, 0, 1, 0, 2'b00, 64'h0,  0);
        tbl[10] = mk(2'b00, 2'b00, 1, 1, 1, 64'hB0, 1, 2'b00, 0, 0, 0, 0, 2'b00, 64'h0,  0);
        tbl[11] = mk(2'b00, 2'b00, 1, 1, 1, 64'hB1, 1, 2'b00, 0, 0, 0, 0, 2'b01, 64'hB0, 0);
        tbl[12] = mk(2'b10, 2'b10, 0, 1, 0, 64'h0,  1, 2'b10, 0, 0, 0, 0, 2'b10, 64'hB1, 0);
        tbl[13] = mk(2'b00, 2'b00, 0, 1, 0, 64'h0,  1, 2'b00, 1, 1, 1, 1, 2'b00, 64'h0,  0);
        tbl[14] = mk(2'b00, 2'b00, 0, 1, 0, 64'h0,  1, 2'b00, 1, 0, 1, 1, 2'b00, 64'h0,  0);
        tbl[15] = mk(2'b00, 2'b00, 0, 1, 0, 64'h0,  1, 2'b00, 1, 0, 1, 1, 2'b00, 64'h0,  0);
        tbl[16] = mk(2'b00, 2'b00, 1, 1, 0, 64'h0,  1, 2'b00, 1, 0, 1, 1, 2'b00, 64'h0,  0);
        tbl[17] = mk(2'b00, 2'b00, 1, 1, 0, 64'h0,  1, 2'b00, 0, 0, 0, 0, 2'b00, 64'h0,  0);
        tbl[18] = mk(2'b00, 2'b00, 1, 1, 1, 64'hEE, 1, 2'b00, 0, 0, 0, 0, 2'b00, 64'h0,  0);
        tbl[19] = mk(2'b00, 2'b00, 1, 1, 0, 64'h0,  1, 2'b00, 0, 0, 0, 0, 2'b00, 64'h0,  1);
        tbl[20] = mk(2'b00, 2'b00, 1, 1, 0, 64'h0,  1, 2'b00, 0, 0, 0, 0, 2'b00, 64'h0,  1);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Fill all eight tags; a ninth read waits while a write still gets through.
        for (int i = 0; i < 8; i++) begin
            step(mk(2'b01, 2'b00, 1, 1, 0, 64'h0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 64'h0, 1),
                 $sformatf("fill%0d.g", i));
            step(mk(2'b01, 2'b00, 1, 1, 0, 64'h0, 1, 2'b00, 1, 0, 0, 0, 2'b00, 64'h0, 1),
                 $sformatf("fill%0d.i", i));
        end
        step(mk(2'b11, 2'b10, 1, 1, 0, 64'h0,  1, 2'b10, 0, 0, 0, 0, 2'b00, 64'h0,  1), "full.wr_g");
        step(mk(2'b01, 2'b00, 1, 1, 0, 64'h0,  1, 2'b00, 1, 1, 1, 1, 2'b00, 64'h0,  1), "full.wr_i");
        step(mk(2'b01, 2'b00, 1, 1, 0, 64'h0,  1, 2'b00, 0, 0, 0, 0, 2'b00, 64'h0,  1), "full.hold");
        step(mk(2'b01, 2'b00, 1, 1, 1, 64'hC0, 1, 2'b00, 0, 0, 0, 0, 2'b00, 64'h0,  1), "full.pop");
        step(mk(2'b01, 2'b00, 1, 1, 0, 64'h0,  1, 2'b01, 0, 0, 0, 0, 2'b01, 64'hC0, 1), "full.free");
        step(mk(2'b00, 2'b00, 1, 1, 0, 64'h0,  1, 2'b00, 1, 0, 0, 0, 2'b00, 64'h0,  1), "full.rd_i");
        for (int i = 0; i < 8; i++) begin
            step(mk(2'b00, 2'b00, 1, 1, 1, 64'hD0 + 64'(i), 1, 2'b00, 0, 0, 0, 0,
                    (i == 0) ? 2'b00 : 2'b01, (i == 0) ? 64'h0 : 64'hD0 + 64'(i - 1), 1),
                 $sformatf("drain%0d", i));
        end
        step(mk(2'b00, 2'b00, 1, 1, 0, 64'h0, 1, 2'b00, 0, 0, 0, 0, 2'b01, 64'hD7, 1), "drain.end");

        // Reset in the middle of a write, with a read still outstanding.
        step(mk(2'b10, 2'b00, 1, 1, 0, 64'h0, 1, 2'b10, 0, 0, 0, 0, 2'b00, 64'h0, 1), "rst.rd_g");
        step(mk(2'b00, 2'b00, 1, 1, 0, 64'h0, 1, 2'b00, 1, 0, 1, 0, 2'b00, 64'h0, 1), "rst.rd_i");
        step(mk(2'b01, 2'b01, 0, 0, 0, 64'h0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 64'h0, 1), "rst.wr_g");
        step(mk(2'b00, 2'b00, 0, 0, 0, 64'h0, 1, 2'b00, 1, 1, 0, 1, 2'b00, 64'h0, 1), "rst.wr_i");
        #1;
        rst_n = 1'b0;
        req_v = 2'b11;
        #1;
        chk_quiet("rst.async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_v = 2'b00;
        step(mk(2'b00, 2'b00, 1, 1, 1, 64'hF0, 1, 2'b00, 0, 0, 0, 0, 2'b00, 64'h0, 0), "post.beat");
        step(mk(2'b11, 2'b00, 1, 1, 0, 64'h0,  1, 2'b01, 0, 0, 0, 0, 2'b00, 64'h0, 1), "post.g0");
        step(mk(2'b11, 2'b00, 1, 1, 0, 64'h0,  1, 2'b00, 1, 0, 0, 0, 2'b00, 64'h0, 1), "post.i0");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
